dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS single-clock core: it sits on the core's data port (memwrite/memread, dataadr, writedata) and answers each access after a fixed wait-state latency with a one-cycle ready pulse. It owns the word-addressed data RAM and optionally carries a hardware pass/fail checker for the standard program's completion write (word 7 stored to address 84), so self-test results are visible without a bench monitor.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 23 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, default checker constants and access-error decode for dmem_responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  localparam logic [31:0] DefPassAddr    = 32'd84;
  localparam logic [31:0] DefPassData    = 32'd7;
  localparam logic [31:0] DefScratchAddr = 32'd80;

  // Misaligned or beyond the end of the RAM.
  function automatic logic addr_bad(input logic [31:0] adr, input int unsigned depth_words);
    return (adr[1:0] != 2'b00) || (adr >= (32'(depth_words) << 2));
  endfunction

  function automatic logic access_err(input logic [31:0] adr, input int unsigned depth_words,
                                      input logic rd, input logic wr);
    return addr_bad(adr, depth_words) || (rd && wr);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with synchronous write and registered read; contents survive reset.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed wait-state latency.
// Optional pass/fail checker on store commits when DMEM_PASS_CHECK_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] PASS_ADDR    = DefPassAddr,
  parameter logic [31:0] PASS_DATA    = DefPassData,
  parameter logic [31:0] SCRATCH_ADDR = DefScratchAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic        pass,
  output logic        fail
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, wdata_q;
  logic        write_q, bad_q, err_q;
  logic        accept, commit;
  logic [31:0] ram_rdata;
  logic [AW-1:0] ram_raddr;

  assign accept = (state_q == StIdle) && (memread || memwrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        adr_q   <= dataadr;
        wdata_q <= writedata;
        write_q <= memwrite;
        bad_q   <= addr_bad(dataadr, DEPTH_WORDS);
        err_q   <= access_err(dataadr, DEPTH_WORDS, memread, memwrite);
      end
    end
  end

  // Read port follows the live address in IDLE so LATENCY=1 still has data on DONE entry.
  assign ram_raddr = (state_q == StIdle) ? dataadr[AW+1:2] : adr_q[AW+1:2];

  // A read+write collision is still a write; only bad addresses drop it.
  assign commit = (state_q == StDone) && write_q && !bad_q;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (commit),
    .waddr(adr_q[AW+1:2]),
    .wdata(wdata_q),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign ready    = (state_q == StDone);
  assign err      = (state_q == StDone) && err_q;
  assign readdata = ((state_q == StDone) && !bad_q) ? ram_rdata : '0;

`ifdef DMEM_PASS_CHECK_EN
  logic pass_q, pass_d, fail_q, fail_d;

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (commit && !err_q && !pass_q && !fail_q) begin
      if ((adr_q == PASS_ADDR) && (wdata_q == PASS_DATA)) begin
        pass_d = 1'b1;
      end else if (adr_q != SCRATCH_ADDR) begin
        fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PASS_ADDR, PASS_DATA, SCRATCH_ADDR, adr_q};
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=64).
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] dataadr, writedata;
  logic [31:0] readdata;
  logic        ready, err, pass, fail;

  int errors = 0;
  int checks = 0;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .dataadr  (dataadr),
    .writedata(writedata),
    .readdata (readdata),
    .ready    (ready),
    .err      (err),
    .pass     (pass),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Issues one request, waits (bounded) for ready, then samples the cycle after ready.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] adr,
                           input logic [31:0] data, output logic [31:0] rdat,
                           output logic e, output int lat, output logic rdy_after);
    rdat = '0;
    e    = 1'b0;
    lat  = -1;
    memwrite  = wr;
    memread   = rd;
    dataadr   = adr;
    writedata = data;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat  = i;
        rdat = readdata;
        e    = err;
        break;
      end
    end
    memwrite = 1'b0;
    memread  = 1'b0;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memread = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, err, pass, fail} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {ready, err, pass, fail});
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata: got %h expected 0", readdata);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, err, pass, fail} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_flags: got %b expected 0000", {ready, err, pass, fail});
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL idle_readdata: got %h expected 0", readdata);
    end
  endtask

  task automatic test_round_trip();
    logic [31:0] d; logic e, ra; int lat;
    do_access(1'b1, 1'b0, 32'd8, 32'h1234_5678, d, e, lat, ra);
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL store_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (ra !== 1'b0) begin
      errors++; $display("FAIL store_ready_pulse: got %b expected 0", ra);
    end
    do_access(1'b0, 1'b1, 32'd8, 32'h0, d, e, lat, ra);
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL load_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (d !== 32'h1234_5678 || e !== 1'b0) begin
      errors++; $display("FAIL load_8: got %h err=%b expected 12345678 err=0", d, e);
    end
    checks++;
    if (ra !== 1'b0 || readdata !== 32'h0) begin
      errors++; $display("FAIL after_done: got ready=%b rd=%h expected 0/0", ra, readdata);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] d; logic e, ra; int lat;
    do_access(1'b1, 1'b0, 32'hFC, 32'hCAFE_F00D, d, e, lat, ra);
    checks++;
    if (e !== 1'b0 || lat !== LAT) begin
      errors++; $display("FAIL store_fc: got err=%b lat=%0d expected 0/%0d", e, lat, LAT);
    end
    do_access(1'b0, 1'b1, 32'hFC, 32'h0, d, e, lat, ra);
    checks++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0) begin
      errors++; $display("FAIL load_fc: got %h err=%b expected cafef00d err=0", d, e);
    end
    // 0x100 aliases word 0 if range checking were missing.
    do_access(1'b1, 1'b0, 32'h0, 32'hA5A5_0000, d, e, lat, ra);
    do_access(1'b1, 1'b0, 32'h100, 32'hBAD0_0100, d, e, lat, ra);
    checks++;
    if (e !== 1'b1 || lat !== LAT) begin
      errors++; $display("FAIL store_100_err: got err=%b lat=%0d expected 1/%0d", e, lat, LAT);
    end
    do_access(1'b0, 1'b1, 32'h0, 32'h0, d, e, lat, ra);
    checks++;
    if (d !== 32'hA5A5_0000) begin
      errors++; $display("FAIL ram_unchanged_0: got %h expected a5a50000", d);
    end
    do_access(1'b0, 1'b1, 32'd6, 32'h0, d, e, lat, ra);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL load_6: got err=%b rd=%h expected err=1 rd=0", e, d);
    end
    do_access(1'b1, 1'b1, 32'h20, 32'h55, d, e, lat, ra);
    checks++;
    if (e !== 1'b1 || lat !== LAT) begin
      errors++; $display("FAIL rd_wr_both: got err=%b lat=%0d expected 1/%0d", e, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int r1 = -1, r2 = -1, n = 0;
    logic [31:0] d; logic e, ra; int lat;
    memwrite = 1'b1; memread = 1'b0; dataadr = 32'd12; writedata = 32'h0000_AAAA;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        n++;
        if (n == 1) begin
          r1 = i;
          writedata = 32'h0000_BBBB;
        end else begin
          r2 = i;
          memwrite = 1'b0;
          break;
        end
      end
    end
    memwrite = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (r1 !== LAT) begin
      errors++; $display("FAIL held_first: got %0d expected %0d", r1, LAT);
    end
    checks++;
    if (r2 !== 2 * LAT + 1) begin
      errors++; $display("FAIL held_second: got %0d expected %0d", r2, 2 * LAT + 1);
    end
    do_access(1'b0, 1'b1, 32'd12, 32'h0, d, e, lat, ra);
    checks++;
    if (d !== 32'h0000_BBBB) begin
      errors++; $display("FAIL held_commit: got %h expected 0000bbbb", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic e, ra; int lat;
    logic seen = 1'b0;
    do_access(1'b1, 1'b0, 32'd16, 32'h0000_1111, d, e, lat, ra);
    memwrite = 1'b1; dataadr = 32'd16; writedata = 32'h0000_DEAD;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_async_ready: got %b expected 0", ready);
    end
    memwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    if (ready) seen = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_no_ready: got %b expected 0", seen);
    end
    do_access(1'b0, 1'b1, 32'd16, 32'h0, d, e, lat, ra);
    checks++;
    if (d !== 32'h0000_1111) begin
      errors++; $display("FAIL reset_drop_write: got %h expected 00001111", d);
    end
  endtask

  task automatic test_checker();
    logic [31:0] d; logic e, ra; int lat;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
`ifdef DMEM_PASS_CHECK_EN
    do_access(1'b1, 1'b0, 32'd80, 32'd5, d, e, lat, ra);
    checks++;
    if ({pass, fail} !== 2'b00) begin
      errors++; $display("FAIL scratch_write: got pass/fail=%b expected 00", {pass, fail});
    end
    do_access(1'b1, 1'b0, 32'd84, 32'd7, d, e, lat, ra);
    checks++;
    if ({pass, fail} !== 2'b10) begin
      errors++; $display("FAIL pass_set: got pass/fail=%b expected 10", {pass, fail});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd88, 32'd3, d, e, lat, ra);
    checks++;
    if ({pass, fail} !== 2'b01) begin
      errors++; $display("FAIL fail_set: got pass/fail=%b expected 01", {pass, fail});
    end
    do_access(1'b1, 1'b0, 32'd84, 32'd7, d, e, lat, ra);
    checks++;
    if ({pass, fail} !== 2'b01) begin
      errors++; $display("FAIL fail_sticky: got pass/fail=%b expected 01", {pass, fail});
    end
`else
    do_access(1'b1, 1'b0, 32'd88, 32'd3, d, e, lat, ra);
    do_access(1'b1, 1'b0, 32'd84, 32'd7, d, e, lat, ra);
    checks++;
    if ({pass, fail} !== 2'b00) begin
      errors++; $display("FAIL checker_off: got pass/fail=%b expected 00", {pass, fail});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_boundaries();
    test_back_to_back();
    test_mid_reset();
    test_checker();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
